// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM register bank:
//   - register address map (ADDR_*)
//   - full-duty constant and the last counter value of a PWM period
//   - duty_level(): compares the PWM counter with the active duty
// No ports; imported by pwm_timebase and pwm_reg_bank.
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam logic [6:0] ADDR_EN_LO  = 7'h00;
    localparam logic [6:0] ADDR_EN_HI  = 7'h01;
    localparam logic [6:0] ADDR_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY   = 7'h04;

    localparam logic [7:0] DUTY_FULL    = 8'hFF;
    localparam logic [7:0] PWM_CNT_LAST = 8'hFF;

    // 0xFF is forced to a solid high so that "full" duty has no low step,
    // which a plain cnt < duty compare could never reach.
    function automatic logic duty_level(input logic [7:0] cnt,
                                        input logic [7:0] duty);
        if (duty == DUTY_FULL) begin
            return 1'b1;
        end
        return (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// ---------------------------------------------------------------------------
// pwm_timebase
// Prescaler plus 8-bit PWM step counter.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   tick     out  1 in the last clk cycle of each prescaler interval
//   pwm_cnt  out  current PWM step, 0..255
//   wrap     out  1 in the last clk cycle of a PWM period (tick at step 255)
// ---------------------------------------------------------------------------
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [7:0] pwm_cnt,
    output logic       wrap
);

    // 16 bits covers the whole legal CLK_DIV range, including CLK_DIV=1.
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        tick      = (pre_cnt_q == DIV_LAST);
        wrap      = tick && (pwm_cnt_q == PWM_CNT_LAST);
        pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
        // 8-bit add wraps 255 -> 0 on its own.
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= 16'd0;
            pwm_cnt_q <= 8'd0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/pwm_reg_bank.sv
// ---------------------------------------------------------------------------
// pwm_reg_bank
// Register bank for a 16-channel PWM/static output block. Each channel is
// either a static level (en_out) or gated by the shared PWM waveform
// (pwm_en). duty_shadow is double-buffered into duty_active at each period
// wrap so a duty change never produces a truncated period.
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   wr_valid      in   single-cycle write strobe (always accepted)
//   wr_addr[6:0]  in   write address
//   wr_data[7:0]  in   write data
//   rd_addr[6:0]  in   readback address
//   rd_data[7:0]  out  combinational readback, 0 for unimplemented addresses
//   pwm_out[15:0] out  registered channel outputs
//   period_start  out  registered pulse, first cycle pwm_out shows step 0
// ---------------------------------------------------------------------------
module pwm_reg_bank
    import pwm_pkg::*;
#(
    parameter int CLK_DIV  = 10,
    parameter int NUM_REGS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [6:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    logic        tick;
    logic [7:0]  pwm_cnt;
    logic        wrap;

    logic [15:0] en_out_q,      en_out_d;
    logic [15:0] pwm_en_q,      pwm_en_d;
    logic [7:0]  duty_shadow_q, duty_shadow_d;
    logic [7:0]  duty_active_q, duty_active_d;
    logic [15:0] pwm_out_q,     pwm_out_d;
    logic        wrap_p1_q;
    logic        period_start_q;

    logic        wr_hit;
    logic        duty_load;
    logic        pwm_level;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .pwm_cnt (pwm_cnt),
        .wrap    (wrap)
    );

    always_comb begin
        en_out_d      = en_out_q;
        pwm_en_d      = pwm_en_q;
        duty_shadow_d = duty_shadow_q;
        wr_hit        = wr_valid && ({1'b0, wr_addr} < NUM_REGS_W);
        if (wr_hit) begin
            unique case (wr_addr)
                ADDR_EN_LO:  en_out_d[7:0]  = wr_data;
                ADDR_EN_HI:  en_out_d[15:8] = wr_data;
                ADDR_PWM_LO: pwm_en_d[7:0]  = wr_data;
                ADDR_PWM_HI: pwm_en_d[15:8] = wr_data;
                ADDR_DUTY:   duty_shadow_d  = wr_data;
                default:     ;
            endcase
        end
    end

    // The load samples the registered shadow, so a duty write landing on
    // the wrap edge itself only takes effect one period later.
    always_comb begin
        duty_load     = tick && (pwm_cnt == PWM_CNT_LAST);
        duty_active_d = duty_load ? duty_shadow_q : duty_active_q;
    end

    always_comb begin
        pwm_level = duty_level(pwm_cnt, duty_active_q);
        // Per bit: en_out AND (pwm_en ? level : 1).
        pwm_out_d = en_out_q & (~pwm_en_q | {16{pwm_level}});
    end

    always_comb begin
        rd_data = 8'h00;
        if ({1'b0, rd_addr} < NUM_REGS_W) begin
            unique case (rd_addr)
                ADDR_EN_LO:  rd_data = en_out_q[7:0];
                ADDR_EN_HI:  rd_data = en_out_q[15:8];
                ADDR_PWM_LO: rd_data = pwm_en_q[7:0];
                ADDR_PWM_HI: rd_data = pwm_en_q[15:8];
                ADDR_DUTY:   rd_data = duty_shadow_q;
                default:     rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out_q      <= 16'h0000;
            pwm_en_q      <= 16'h0000;
            duty_shadow_q <= 8'h00;
            duty_active_q <= 8'h00;
        end else begin
            en_out_q      <= en_out_d;
            pwm_en_q      <= pwm_en_d;
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
        end
    end

    // Stage p1: counter and duty reach step 0 of the new period.
    // Stage p2: pwm_out_q shows step 0, so period_start follows wrap by two
    // edges, and a fresh reset (counter already at 0) never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out_q      <= 16'h0000;
            wrap_p1_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pwm_out_q      <= pwm_out_d;
            wrap_p1_q      <= wrap;
            period_start_q <= wrap_p1_q;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_reg_bank
// Drives pwm_reg_bank (CLK_DIV=4) with directed and random register writes.
// A behavioural model derives the expected outputs from the number of clock
// edges since reset release: PWM step = (edges / CLK_DIV) mod 256, and the
// active duty is whatever the shadow held just before the last period
// boundary. Every cycle the DUT outputs are compared with the model; a set
// of literal expectations pins the model's own timing and duty behaviour.
// ---------------------------------------------------------------------------
module tb_pwm_reg_bank;

    localparam int D = 4;
    localparam int P = 256 * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [15:0] pwm_out;
    logic        period_start;

    int vectors = 0;
    int miscompares = 0;

    pwm_reg_bank #(
        .CLK_DIV  (D),
        .NUM_REGS (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [15:0] m_en, m_pen, m_out;
    logic [7:0]  m_sh, m_act;
    logic        m_ps;
    int          m_s;   // clock edges seen since reset release

    initial begin
        m_en = '0; m_pen = '0; m_sh = '0; m_act = '0;
        m_out = '0; m_ps = 1'b0; m_s = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_en = '0; m_pen = '0; m_sh = '0; m_act = '0;
                m_out = '0; m_ps = 1'b0; m_s = 0;
            end else begin
                int  step_no;
                logic lvl;
                step_no = (m_s / D) % 256;
                lvl = (m_act == 8'hFF) ? 1'b1 : (step_no < int'(m_act));
                for (int i = 0; i < 16; i++)
                    m_out[i] = m_en[i] && (!m_pen[i] || lvl);
                // This edge is number m_s+1; edge k*P is a period boundary,
                // and its step-0 output is visible one edge later.
                m_ps = ((m_s + 1) % P == 1) && (m_s + 1 > P);
                if ((m_s + 1) % P == 0) m_act = m_sh;
                if (wr_valid) begin
                    case (wr_addr)
                        7'd0: m_en[7:0]   = wr_data;
                        7'd1: m_en[15:8]  = wr_data;
                        7'd2: m_pen[7:0]  = wr_data;
                        7'd3: m_pen[15:8] = wr_data;
                        7'd4: m_sh        = wr_data;
                        default: ;
                    endcase
                end
                m_s = m_s + 1;
            end
        end
    end

    function automatic logic [7:0] mrd(input logic [6:0] a);
        case (a)
            7'd0: return m_en[7:0];
            7'd1: return m_en[15:8];
            7'd2: return m_pen[7:0];
            7'd3: return m_pen[15:8];
            7'd4: return m_sh;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then release the write strobe.
    task automatic step();
        @(negedge clk);
        chk("pwm_out", 32'(pwm_out), 32'(m_out));
        chk("period_start", 32'(period_start), 32'(m_ps));
        chk("rd_data", 32'(rd_data), 32'(mrd(rd_addr)));
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        wr_addr = a; wr_data = d; wr_valid = 1'b1;
        step();
    endtask

    task automatic read_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic wait_ps();
        for (int i = 0; i < 2 * P + 16; i++) begin
            step();
            if (period_start === 1'b1) return;
        end
        chk("period_start_timeout", 32'd0, 32'd1);
    endtask

    // Measure one full period beginning at the next period_start pulse.
    task automatic measure_period(output int highs, output int bad);
        wait_ps();
        highs = 0; bad = 0;
        for (int i = 0; i < P; i++) begin
            if (i > 0) step();
            highs += int'(pwm_out[0]);
            if (pwm_out[15:1] !== 15'h7FFF) bad++;
        end
    endtask

    initial begin
        int h, b, n;
        rst_n = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_pwm_out", 32'(pwm_out), 32'h0);
        chk("reset_period_start", 32'(period_start), 32'h0);
        repeat (3) step();
        rst_n = 1'b1;

        // Static outputs and readback.
        do_write(7'h00, 8'hFF);
        do_write(7'h01, 8'h00);
        step();
        chk("static_00FF", 32'(pwm_out), 32'h00FF);
        read_chk("rd_en_lo", 7'h00, 8'hFF);

        // 50% duty on bit 0, all other bits static high.
        do_write(7'h00, 8'hFF);
        do_write(7'h01, 8'hFF);
        do_write(7'h02, 8'h01);
        do_write(7'h03, 8'h00);
        do_write(7'h04, 8'h80);
        measure_period(h, b);
        chk("duty80_high", 32'(h), 32'd512);
        chk("duty80_static_bits", 32'(b), 32'd0);

        // Duty boundaries; the second period is guaranteed to use the new duty.
        do_write(7'h04, 8'h00);
        measure_period(h, b);
        measure_period(h, b);
        chk("duty00_high", 32'(h), 32'd0);
        do_write(7'h04, 8'hFF);
        measure_period(h, b);
        measure_period(h, b);
        chk("dutyFF_high", 32'(h), 32'd1024);
        do_write(7'h04, 8'h01);
        measure_period(h, b);
        measure_period(h, b);
        chk("duty01_high", 32'(h), 32'd4);
        chk("duty01_static_bits", 32'(b), 32'd0);

        // Duty write landing exactly on the wrap edge.
        do_write(7'h04, 8'h80);
        for (int i = 0; i < P + 4; i++) begin
            if ((m_s + 1) % P == 0) break;
            step();
        end
        do_write(7'h04, 8'h40);
        measure_period(h, b);
        chk("wrapwrite_first_high", 32'(h), 32'd512);
        measure_period(h, b);
        chk("wrapwrite_second_high", 32'(h), 32'd256);

        // Unimplemented address.
        do_write(7'h05, 8'hAA);
        read_chk("rd_addr5", 7'h05, 8'h00);
        read_chk("keep_en_lo", 7'h00, 8'hFF);
        read_chk("keep_en_hi", 7'h01, 8'hFF);
        read_chk("keep_pwm_lo", 7'h02, 8'h01);
        read_chk("keep_pwm_hi", 7'h03, 8'h00);
        read_chk("keep_duty", 7'h04, 8'h40);

        // Mid-period reset.
        repeat (300) step();
        rst_n = 1'b0;
        #1;
        chk("midreset_pwm_out", 32'(pwm_out), 32'h0);
        chk("midreset_period_start", 32'(period_start), 32'h0);
        read_chk("midreset_rd", 7'h00, 8'h00);
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 3000; i++) begin
            step();
            if (period_start === 1'b1) begin
                n = i;
                break;
            end
        end
        // Wrap on edge 1024 after release; the pulse rises on edge 1025.
        chk("first_ps_after_reset", 32'(n), 32'd1025);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_addr  = 7'($urandom_range(0, 7));
                wr_data  = 8'($urandom);
                wr_valid = 1'b1;
            end
            rd_addr = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_reg_bank.md
PWM_REG_BANK -- requirements
Module: pwm_reg_bank

Interface
REQ-001 Parameter CLK_DIV, default 10: number of clk cycles per PWM counter step; legal range 1..65535.
REQ-002 Parameter NUM_REGS, default 5: number of implemented register addresses, 0..NUM_REGS-1.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  single-cycle write strobe from the upstream SPI stage.
REQ-006 wr_addr  input  7  register address of the write.
REQ-007 wr_data  input  8  register write data.
REQ-008 rd_addr  input  7  readback address.
REQ-009 rd_data  output  8  combinational readback of the register at rd_addr; 0 for unimplemented addresses.
REQ-010 pwm_out  output  16  registered PWM/static output bits.
REQ-011 period_start  output  1  registered one-cycle pulse marking the first cycle of each PWM period.

Function
REQ-012 Register map: 0x00 en_out[7:0]; 0x01 en_out[15:8]; 0x02 pwm_en[7:0]; 0x03 pwm_en[15:8]; 0x04 duty_shadow.
REQ-013 A write with wr_valid=1 and wr_addr<NUM_REGS SHALL update the addressed register at that clk edge; wr_valid is always accepted and has no backpressure.
REQ-014 Writes with wr_addr>=NUM_REGS SHALL be ignored without side effects.
REQ-015 Prescaler pre_cnt SHALL count 0..CLK_DIV-1 and wrap; tick=1 when pre_cnt==CLK_DIV-1.
REQ-016 8-bit pwm_cnt SHALL increment on tick and wrap 255->0; PWM period = 256*CLK_DIV clk cycles.
REQ-017 duty_active SHALL load duty_shadow on the edge where tick=1 and pwm_cnt==255, i.e. at every period wrap; at no other time.
REQ-018 A duty_shadow write on the same edge as a wrap load: duty_active takes the pre-write shadow value; the new value applies from the following period.
REQ-019 pwm_level = 1 when duty_active==0xFF; otherwise (pwm_cnt < duty_active); duty 0x00 gives a constant 0.
REQ-020 For each bit i, pwm_out[i] SHALL be registered as en_out[i] AND (pwm_en[i] ? pwm_level : 1).
REQ-021 Latency: pwm_out reflects register and counter state one clk edge after that state is updated.
REQ-022 period_start SHALL be 1 for exactly the one cycle in which registered pwm_out first reflects pwm_cnt==0 of a new period.
REQ-023 pwm_en[i]=1 with en_out[i]=0 SHALL hold pwm_out[i]=0.

Reset
REQ-024 rst_n low SHALL immediately clear en_out, pwm_en, duty_shadow, duty_active, pre_cnt, pwm_cnt, pwm_out and period_start to 0.
REQ-025 Reset asserted mid-period SHALL abandon that period; after release, counting restarts at pwm_cnt=0, pre_cnt=0.
REQ-026 The first period_start pulse after reset release SHALL occur at the first wrap, 256*CLK_DIV cycles after release; no pulse is generated at release itself.

Structure
REQ-027 Shared package pwm_pkg SHALL hold the register address constants (ADDR_EN_LO, ADDR_EN_HI, ADDR_PWM_LO, ADDR_PWM_HI, ADDR_DUTY) and the 0xFF full-duty constant.
REQ-028 Prescaler plus pwm_cnt SHALL be one sub-module, pwm_timebase, with outputs tick, pwm_cnt and wrap.
REQ-029 The register bank, duty double-buffer and output logic SHALL reside in pwm_reg_bank.

Verification (CLK_DIV=4)
REQ-030 Reset release; write 0x00=0xFF, 0x01=0x00 -> pwm_out==16'h00FF one edge after the second write is registered; rd_data(0x00)==0xFF.
REQ-031 en_out=0xFFFF, pwm_en=0x0001, duty=0x80 -> from the second period onward, pwm_out[0] is high for 128*4 and low for 128*4 cycles; other bits stay static at 1.
REQ-032 Duty boundaries: 0x00 -> pwm_out[0] is constant 0; 0xFF -> pwm_out[0] is constant 1 for a full period; 0x01 -> high for 4 cycles per 1024.
REQ-033 Write duty=0x40 on the exact wrap edge while the shadow holds 0x80 -> the next period runs at 128 high-steps, and the following period at 64.
REQ-034 Write to address 0x05 with data 0xAA -> all registers are unchanged and rd_data(0x05)==0.
REQ-035 Assert rst_n mid-period with pwm_out active -> all outputs are 0 immediately; after release, period_start first pulses 1024 cycles later.
